// File: rtl/addseq_pkg.sv
// Shared constants for the multiword add/subtract sequencer: FSM encodings and slice width.
package addseq_pkg;

  localparam int unsigned SLICE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Slice index width; a single-slice build still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational 8-bit ripple-carry adder, one full adder per bit.
module ripple_carry_adder
  import addseq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract computed one 8-bit slice per cycle through a single shared ripple adder.
module multiword_add_sequencer
  import addseq_pkg::*;
#(
  parameter int unsigned NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [SLICE_W*NWORDS-1:0] a,
  input  logic [SLICE_W*NWORDS-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [SLICE_W*NWORDS-1:0] result,
  output logic                      cout,
  output logic                      overflow
);

  localparam int unsigned W    = SLICE_W * NWORDS;
  localparam int unsigned IW   = idx_width(NWORDS);
  localparam int unsigned LAST = NWORDS - 1;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] sum_sl;
  logic               cout_sl;
  logic               last_slice;

  // Operand slice select; B is inverted for subtract and the +1 comes in via the carry.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
      end
    end
  end

  ripple_carry_adder u_rca (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (cout_sl)
  );

  assign last_slice = (idx_q == IW'(LAST));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < int'(NWORDS); i++) begin
          if (idx_q == IW'(i)) begin
            result_d[i*SLICE_W +: SLICE_W] = sum_sl;
          end
        end
        carry_d = cout_sl;
        if (last_slice) begin
          // Flags are taken from the MSB slice; the index parks on the last slice.
          cout_d  = cout_sl;
          ovf_d   = (a_sl[SLICE_W-1] ^ sum_sl[SLICE_W-1]) &
                    (b_sl[SLICE_W-1] ^ sum_sl[SLICE_W-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: vector table plus directed corner sequences, checked via a scoreboard.
module tb_multiword_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 8 * NW;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  multiword_add_sequencer #(
    .NWORDS (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    vec_t v;
    int   due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t         m;
    logic [W:0]   t;
    logic [W-1:0] yy;
    yy    = s ? ~y : y;
    t     = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    m.s   = s;
    m.a   = x;
    m.b   = y;
    m.res = t[W-1:0];
    m.co  = t[W];
    m.ov  = (x[W-1] ^ t[W-1]) & (yy[W-1] ^ t[W-1]);
    return m;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("result", result, mon_e.v.res);
        check("cout", W'(cout), W'(mon_e.v.co));
        check("overflow", W'(overflow), W'(mon_e.v.ov));
        check("done_latency", W'(cyc), W'(mon_e.due));
      end
    end
  end

  // Called just after a rising edge (or at a falling edge); start is sampled on the next edge.
  task automatic launch(input vec_t v, input bit push);
    exp_t e;
    a     = v.a;
    b     = v.b;
    sub   = v.s;
    start = 1'b1;
    if (push) begin
      e.v   = v;
      e.due = cyc + 1 + NW;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", W'(busy), W'(1));
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * NW + 4 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 want done=1", name);
    end
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;

    tbl[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 32'h12345678, 32'h0FEDCBA9, 32'h22222221, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0};

    #1 rst = 1'b1;
    #2;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      launch(tbl[i], 1'b1);
      wait_done("table");
    end

    for (int i = 0; i < 6; i++) begin
      v = model(1'($urandom_range(0, 1)), $urandom, $urandom);
      @(posedge clk);
      #1;
      launch(v, 1'b1);
      wait_done("random");
    end

    // start with new operands during RUN is ignored; operand changes while busy are harmless
    @(posedge clk);
    #1;
    launch(model(1'b0, 32'h11111111, 32'h22222222), 1'b1);
    a     = 32'hDEADBEEF;
    b     = 32'hCAFEF00D;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'h0BADF00D;
    wait_done("ignore_start");
    repeat (2 * NW + 2) @(negedge clk);
    check("idle_after_ignored_start", W'(busy), W'(0));

    // start held through DONE: back-to-back operation
    @(posedge clk);
    #1;
    launch(model(1'b1, 32'd100, 32'd1), 1'b1);
    wait_done("b2b_first");
    launch(model(1'b0, 32'h80000000, 32'h80000000), 1'b1);
    check("done_single_cycle", W'(done), W'(0));
    wait_done("b2b_second");

    // reset in the second RUN cycle aborts the operation
    @(posedge clk);
    #1;
    launch(model(1'b0, 32'h11111111, 32'h01010101), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_result", result, '0);
    check("abort_cout", W'(cout), W'(0));
    check("abort_overflow", W'(overflow), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    v   = '{1'b0, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0};
    launch(v, 1'b1);
    wait_done("after_reset");
    repeat (2 * NW) @(negedge clk);
    check("scoreboard_empty", W'(sbq.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter NWORDS, default 4, number of 8-bit slices; operand width W = 8*NWORDS.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only when accepted (REQ-011).
REQ-005 sub  input  1  0 = add (a+b), 1 = subtract (a-b); latched with the operands.
REQ-006 a  input  W  operand A; latched on acceptance.
REQ-007 b  input  W  operand B; latched on acceptance.
REQ-008 busy  output  1  high while slices are being computed (state RUN).
REQ-009 done  output  1  one-cycle pulse when result, cout and overflow become valid.
REQ-010 result  output  W  sum or difference, plus cout (output, 1, carry out of MSB slice) and overflow (output, 1, signed overflow flag).

Function
REQ-011 FSM states: IDLE, RUN, DONE; start is accepted only in IDLE or DONE, and ignored in RUN.
REQ-012 Acceptance: latch a, b and sub; clear slice index to 0; load carry register with sub; go to RUN.
REQ-013 RUN: one 8-bit slice i per cycle; slice operands a[8i+7:8i] and (b[8i+7:8i] XOR {8{sub}}); carry-in from the carry register.
REQ-014 Each RUN cycle: write slice sum to result[8i+7:8i]; carry register <= slice cout; index <= index+1.
REQ-015 RUN to DONE when the slice with index NWORDS-1 is written; exactly NWORDS cycles in RUN.
REQ-016 Latency: if start is accepted at edge k, done = 1 during the cycle after edge k+NWORDS.
REQ-017 done = 1 only in DONE; DONE lasts one cycle, then goes to IDLE, or to RUN if start = 1.
REQ-018 result, cout and overflow hold their last values until the next acceptance.
REQ-019 During RUN, result is partial and unspecified.
REQ-020 cout = final carry register; for sub = 1, cout = 1 means no borrow.
REQ-021 overflow = (a[W-1] XOR result[W-1]) AND (b'[W-1] XOR result[W-1]), where b' is the inverted-if-sub operand.
REQ-022 Index width = clog2(NWORDS), minimum 1; the index never wraps past NWORDS-1 in RUN.
REQ-023 Input changes on a, b and sub while busy do not affect the operation in progress.

Reset
REQ-024 When rst is asserted: state = IDLE, busy = 0, done = 0, result = 0, cout = 0, overflow = 0, index = 0, carry register = 0.
REQ-025 Reset asserted mid-RUN aborts the operation immediately; no done pulse follows.
REQ-026 The first start is accepted on the first rising edge after rst is deasserted.

Structure
REQ-027 State encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the slice width constant 8 live in shared package addseq_pkg.
REQ-028 Instantiates exactly one sub-module: the team's combinational 8-bit ripple_carry_adder (a, b, cin, sum, cout), shared across all slices.
REQ-029 No other arithmetic on the datapath; the only logic is operand muxing, the XOR invert, and registers.

Verification
REQ-030 add 0x000000FF + 0x00000001 -> result 0x00000100, cout 0, overflow 0, done at cycle k+NWORDS+1.
REQ-031 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout 1, overflow 0 (carry ripples through all 4 slices).
REQ-032 sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, cout 0; sub 7 - 5 -> result 0x00000002, cout 1.
REQ-033 add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1; sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1.
REQ-034 start pulsed during RUN with new operands -> ignored, first result correct; start held in DONE -> back-to-back op with busy reasserted next cycle.
REQ-035 rst asserted in the 2nd RUN cycle -> all outputs 0 asynchronously, no done; a later start of 3+4 -> result 7.
